// File: rtl/arduino_uart_pkg.sv
// arduino_uart_pkg: types and shared constants for the Arduino UART link.
// The tx state list gains PARITY_BIT only when ARDUINO_UART_TX_PARITY_EN is defined.
package arduino_uart_pkg;

    // 50 MHz system clock at 115200 baud; shared with the receive path
    localparam int DEFAULT_CLKS_PER_BIT = 50_000_000 / 115_200;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
`ifdef ARDUINO_UART_TX_PARITY_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small circular byte buffer in front of the UART shifter.
// Pointers wrap naturally; a separate count distinguishes full from empty.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_BITS-1:0]          din,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Guard both ports so a stray push when full or pop when empty is harmless
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind the write pointer are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/arduino_uart_tx.sv
// arduino_uart_tx: FIFO-buffered UART transmitter driving the Arduino RX pin.
// Default frame is 8N1; defining ARDUINO_UART_TX_PARITY_EN adds an even parity bit (8E1).
module arduino_uart_tx
    import arduino_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_50,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 arduino_output,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t              state;
    tx_state_t              state_next;
    logic [CNT_W-1:0]       baud_cnt;
    logic [CNT_W-1:0]       baud_next;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   line_next;
    logic                   bit_done;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign bit_done  = (baud_cnt == LAST_CNT);

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencing: next state, baud/bit counters, shifter load and the next line level
    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        line_next    = 1'b1;

        case (state)
            IDLE: begin
                baud_next    = '0;
                bit_idx_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_done) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA_BIT;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA_BIT: begin
                if (bit_done) begin
                    baud_next = '0;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_next = '0;
`ifdef ARDUINO_UART_TX_PARITY_EN
                        state_next   = PARITY_BIT;
`else
                        state_next   = STOP_BIT;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef ARDUINO_UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = STOP_BIT;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_done) begin
                    baud_next = '0;
                    // A queued byte starts its frame with no idle gap
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START_BIT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        // The line is registered, so it is derived from where the FSM is going
        case (state_next)
            START_BIT:  line_next = 1'b0;
            DATA_BIT:   line_next = shift_next[bit_idx_next];
`ifdef ARDUINO_UART_TX_PARITY_EN
            PARITY_BIT: line_next = ^shift_next;
`endif
            default:    line_next = 1'b1;
        endcase
    end

    // State, counters, shifter and the glitch-free serial output register
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            arduino_output <= 1'b1;
        end else begin
            state          <= state_next;
            baud_cnt       <= baud_next;
            bit_idx        <= bit_idx_next;
            shift_reg      <= shift_next;
            arduino_output <= line_next;
        end
    end

endmodule
